// File: rtl/seq_match_logger_if.sv
// Bus between a detector-side producer/consumer and seq_match_logger.
// Ports (modport slave = logger):
//   detected    in   match pulse from the sequence detector
//   rd_en       in   pop request for the match-position FIFO
//   rd_data     out  head-of-FIFO cycle index (0 when empty)
//   empty/full  out  FIFO occupancy flags
//   count       out  FIFO occupancy, log2(DEPTH)+1 bits
//   match_count out  saturating total of detections
//   overflow    out  sticky dropped-detection flag
interface seq_match_logger_if #(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             detected;
    logic             rd_en;
    logic [IDX_W-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [OCC_W-1:0] count;
    logic [CNT_W-1:0] match_count;
    logic             overflow;

    modport master (
        output detected, rd_en,
        input  rd_data, empty, full, count, match_count, overflow
    );

    modport slave (
        input  detected, rd_en,
        output rd_data, empty, full, count, match_count, overflow
    );
endinterface

// File: rtl/seq_match_logger.sv
// Logs the cycle index of every sequence-detector match into a small
// first-word-fall-through FIFO, with a saturating match counter and a
// sticky overflow flag for detections lost to a full FIFO.
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of seq_match_logger_if (detected, rd_en in;
//          rd_data, empty, full, count, match_count, overflow out)
module seq_match_logger #(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_match_logger_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [IDX_W-1:0] cyc;
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] match_cnt;
    logic             ovf;

    logic is_empty;
    logic is_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Push/pop qualification; a pop on a full FIFO frees the slot for a same-edge push.
    always_comb begin
        is_empty = (occ == '0);
        is_full  = (occ == OCC_FULL);
        do_pop   = bus.rd_en && !is_empty;
        do_push  = bus.detected && (!is_full || do_pop);
        do_drop  = bus.detected && is_full && !do_pop;
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= cyc;
        end
    end

    // Cycle index, pointers, occupancy, counter and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            match_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            cyc <= cyc + IDX_W'(1);
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (bus.detected && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
            if (do_drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Read side depends on registered state only.
    assign bus.rd_data     = is_empty ? '0 : mem[rd_ptr];
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.count       = occ;
    assign bus.match_count = match_cnt;
    assign bus.overflow    = ovf;
endmodule
